burst_rr_arbiter: RTL
=====================

# burst_rr_arbiter

Round-robin scheduler that shares one modulo-BURST beat counter between NREQ requesters. The winner holds the resource for a fixed burst of BURST beats, or less if it drops its request. Beat index `cnt` counts 0..BURST-1 and wraps like the team's mod-5 counter. The block sits between the requesting blocks and the shared counter datapath, and is the only source of grants to it.

## Interface
- NREQ, 4, number of requesters (2..8)
- BURST, 5, beats per full burst (>=2); counter modulus
- CW, 3, width of `cnt`; must satisfy 2^CW >= BURST
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
- req  input  NREQ  request vector, level-sensitive; bit i = requester i
- gnt  output  NREQ  one-hot grant, registered; all-zero when no grant
- gnt_id  output  3  index of current/last winner, registered
- cnt  output  CW  beat index within current burst, registered
- busy  output  1  high while any gnt bit is high
- last  output  1  busy && cnt==BURST-1, decoded from registers

## Operation
- Internal state: FSM {IDLE, GRANT, GAP}, pointer `ptr` (log2 NREQ bits).
- Reset values: state=IDLE, gnt=0, gnt_id=0, cnt=0, busy=0, last=0, ptr=0.
- Arbitration happens at an edge where state is IDLE, or where a burst ends, and any req bit is 1.
  - The winner is the first set bit of req, scanning cyclically from ptr upward.
  - Next state is GRANT, gnt=onehot(winner), gnt_id=winner, cnt=0.
- GRANT, per edge, evaluated in order:
  1. If req[gnt_id]==0, it is an early release and the burst ends. cnt does not advance.
  2. Else if cnt==BURST-1, it is a full burst and the burst ends.
  3. Else cnt <= cnt+1.
- On burst end:
  - ptr <= (gnt_id+1) mod NREQ.
  - Re-arbitrate in the same edge using the updated ptr. With no gap configured, this gives a back-to-back grant.
  - If no request, the next state is IDLE: gnt=0, cnt=0.
- No preemption: requests arriving mid-burst wait. A continuously requesting winner regains the grant only after every other pending requester has been served.
- Arithmetic: cnt increment is modulo BURST; cnt never exceeds BURST-1. The ptr wrap uses an explicit compare, not truncation, so non-power-of-2 NREQ works.
- Reset mid-burst: gnt drops to 0 at that edge; ptr returns to 0. No partial-burst state is retained.
- req bits above the active grant are ignored except during arbitration.

## Timing
- Latency from req rising (sampled at edge k) to gnt high: visible after edge k, i.e. 1 cycle.
- Full burst: gnt high for exactly BURST cycles; `last` high on the final one.
- Early release: gnt falls after the edge at which req[gnt_id]==0 is sampled.
- Back-to-back grant (macro off): the new gnt is visible in the cycle immediately after `last`, with zero idle cycles. gnt may change one-hot value without passing through 0.
- busy == |gnt in every cycle. gnt is never multi-hot.

## Configuration
- Macro `ARB_GAP_EN`.
- Defined:
  - Every burst end (full or early) enters GAP for exactly one cycle: gnt=0, busy=0, cnt=0.
  - Arbitration is performed at the GAP exit edge using the updated ptr.
  - Grants are therefore separated by exactly one idle cycle.
  - Reset during GAP behaves as reset in any state.
- Undefined: the GAP state is not compiled. Bursts end directly into GRANT or IDLE as described above.

## Test plan
- Reset check: hold rst=0 for 3 cycles with req=4'b1111. Required: gnt=0, busy=0, cnt=0, gnt_id=0, last=0 throughout.
- Single full burst: req=4'b0001 held.
  - gnt=0001 for 5 cycles with cnt 0,1,2,3,4.
  - last high only at cnt=4.
  - Macro off: gnt=0001 again next cycle with cnt=0.
  - Macro on: one cycle of gnt=0 first.
- Round-robin fairness: req=4'b0101 held. Grant sequence 0001(x5), 0100(x5), 0001(x5); gnt_id 0,2,0.
- Early release: req=4'b0011, then drop req[0] while cnt=2.
  - gnt=0001 ends at that edge.
  - Next cycle gnt=0010 (macro off), cnt=0.
- Mid-burst arrival: req=4'b0010 alone, then req[3] rises at cnt=1.
  - gnt=0010 completes all 5 beats.
  - gnt=1000 follows.
- Reset mid-burst: during gnt=0100, cnt=3, pulse rst=0 for one edge.
  - gnt=0, cnt=0 after that edge.
  - With req=4'b0110 held, the first grant after release is 0010, since ptr=0.

Source files
------------

// File: rtl/burst_rr_arbiter.sv
// Round-robin burst arbiter: grants one requester at a time for up to BURST beats.
// Define ARB_GAP_EN to insert one idle cycle between consecutive bursts.
module burst_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int BURST = 5,
  parameter int CW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_id,
  output logic [CW-1:0]   cnt,
  output logic            busy,
  output logic            last
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BURST - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
`ifdef ARB_GAP_EN
  localparam logic [1:0] GAP   = 2'd2;
`endif

  logic [1:0]      state, state_n;
  logic [PW-1:0]   ptr, ptr_n, ptr_wrap, arb_base, cur, win, scan;
  logic [PW:0]     sum;
  logic            found, do_arb, burst_end;
  logic [NREQ-1:0] gnt_n;
  logic [2:0]      id_n;
  logic [CW-1:0]   cnt_n;

  assign cur       = gnt_id[PW-1:0];
  assign burst_end = (state == GRANT) && (!req[cur] || (cnt == CNT_MAX));
  assign ptr_wrap  = (cur == LAST_IDX) ? '0 : cur + PW'(1);

  // Without a gap, a finishing burst re-arbitrates from the already-advanced pointer.
`ifdef ARB_GAP_EN
  assign arb_base = ptr;
`else
  assign arb_base = burst_end ? ptr_wrap : ptr;
`endif

  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    scan  = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      sum = {1'b0, arb_base} + (PW+1)'(j);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      scan = sum[PW-1:0];
      if (req[scan]) begin
        win   = scan;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    id_n    = gnt_id;
    cnt_n   = cnt;
    do_arb  = 1'b0;
    case (state)
      IDLE: do_arb = 1'b1;
      GRANT: begin
        if (burst_end) begin
          ptr_n = ptr_wrap;
          gnt_n = '0;
          cnt_n = '0;
`ifdef ARB_GAP_EN
          state_n = GAP;
`else
          do_arb = 1'b1;
`endif
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef ARB_GAP_EN
      GAP: do_arb = 1'b1;
`endif
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    endcase

    if (do_arb) begin
      if (found) begin
        state_n    = GRANT;
        gnt_n      = '0;
        gnt_n[win] = 1'b1;
        id_n       = 3'(win);
        cnt_n      = '0;
      end else begin
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      gnt    <= gnt_n;
      gnt_id <= id_n;
      cnt    <= cnt_n;
    end
  end

  assign busy = |gnt;
  assign last = busy && (cnt == CNT_MAX);

endmodule
